// File: rtl/sdram_pkg.sv
// Shared constants and FSM state type for the cache-to-SDRC line transfer port.
package sdram_pkg;
   localparam int unsigned AddrWidth = 21;
   localparam int unsigned DataWidth = 32;

   localparam logic [2:0] CmdActivate  = 3'b011;
   localparam logic [2:0] CmdRead      = 3'b101;
   localparam logic [2:0] CmdWrite     = 3'b100;
   localparam logic [2:0] CmdPrecharge = 3'b010;
   localparam logic [2:0] CmdRefresh   = 3'b001;

   typedef enum logic [4:0] {
      Init, Idle, Refresh, RefreshAck, RefreshWait, Activate,
      ActAck, ActWait, Read, ReadAck, ReadData, WriteArm, WriteData,
      Precharge, PreAck, PreWait, Done
   } state_e;
endpackage

// File: rtl/sdram_line_port_if.sv
// Cache-side line request / word streaming bundle of sdram_line_port.
interface sdram_line_port_if;
   import sdram_pkg::*;

   logic                 req_valid;
   logic                 req_write;
   logic [AddrWidth-1:0] req_address;
   logic                 req_ready;
   logic [2:0]           wr_column;
   logic [DataWidth-1:0] wr_data;
   logic [DataWidth-1:0] rd_data;
   logic [2:0]           rd_column;
   logic                 rd_valid;
   logic                 done;

   modport master (
      output req_valid, req_write, req_address, wr_data,
      input  req_ready, wr_column, rd_data, rd_column, rd_valid, done
   );

   modport slave (
      input  req_valid, req_write, req_address, wr_data,
      output req_ready, wr_column, rd_data, rd_column, rd_valid, done
   );
endinterface

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag.
module sdram_refresh_timer #(
   parameter int unsigned Interval = 780
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_expire,
   output logic o_pending
);
   localparam int unsigned CntW = (Interval > 1) ? $clog2(Interval) : 1;

   logic [CntW-1:0] r_count;
   logic            r_pending;

   assign o_expire  = i_enable && (r_count == CntW'(Interval - 1));
   assign o_pending = r_pending;

   // A fresh expiry wins over a clear so a refresh is never lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_pending <= 1'b0;
      end else begin
         if (i_enable) r_count <= o_expire ? '0 : r_count + 1'b1;
         if (o_expire)     r_pending <= 1'b1;
         else if (i_clear) r_pending <= 1'b0;
      end
   end
endmodule

// File: rtl/sdram_line_port.sv
// Line transfer engine: one cache line <-> ACTIVATE / READ|WRITE burst / PRECHARGE on the SDRC,
// with periodic AUTO-REFRESH inserted between requests.
module sdram_line_port
   import sdram_pkg::*;
#(
   parameter int unsigned LineWords       = 8,
   parameter int unsigned ActToRwCycles   = 2,
   parameter int unsigned ReadLatency     = 4,
   parameter int unsigned PrechargeCycles = 2,
   parameter int unsigned RefreshInterval = 780,
   parameter int unsigned RefreshCycles   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sdram_line_port_if.slave     bus,
   output logic                 I_sdrc_cmd_en,
   output logic [2:0]           I_sdrc_cmd,
   output logic [AddrWidth-1:0] I_sdrc_addr,
   output logic [DataWidth-1:0] I_sdrc_data,
   output logic [7:0]           I_sdrc_data_len,
   output logic [3:0]           I_sdrc_dqm,
   input  logic [DataWidth-1:0] O_sdrc_data,
   input  logic                 O_sdrc_init_done,
   input  logic                 O_sdrc_cmd_ack
);
   if (ActToRwCycles < 1 || ActToRwCycles > 15 || ReadLatency < 1 || ReadLatency > 15 ||
       PrechargeCycles < 1 || PrechargeCycles > 15 || RefreshCycles < 1 || RefreshCycles > 15)
   begin : g_bad_delay
      $error("sdram_line_port: delay parameters must be in 1..15");
   end

   localparam logic [2:0] LastCol = 3'(LineWords - 1);

   state_e               r_state, w_state;
   logic [3:0]           r_cnt, w_cnt;
   logic [2:0]           r_col, w_col;
   logic                 r_acked, w_acked;
   logic                 r_wr_last, w_wr_last;
   logic [AddrWidth-1:0] r_addr;
   logic                 r_write;
   logic                 w_accept, w_ref_clear, w_ref_expire, w_ref_pending;

   sdram_refresh_timer #(.Interval(RefreshInterval)) u_refresh (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_enable  (r_state != Init),
      .i_clear   (w_ref_clear),
      .o_expire  (w_ref_expire),
      .o_pending (w_ref_pending)
   );

   assign I_sdrc_dqm = '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= Init;
         r_cnt     <= '0;
         r_col     <= '0;
         r_acked   <= 1'b0;
         r_wr_last <= 1'b0;
         r_addr    <= '0;
         r_write   <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_col     <= w_col;
         r_acked   <= w_acked;
         r_wr_last <= w_wr_last;
         if (w_accept) begin
            r_addr  <= bus.req_address;
            r_write <= bus.req_write;
         end
      end
   end

   always_comb begin
      w_state         = r_state;
      w_cnt           = r_cnt;
      w_col           = r_col;
      w_acked         = r_acked;
      w_wr_last       = r_wr_last;
      w_accept        = 1'b0;
      w_ref_clear     = 1'b0;
      bus.req_ready   = 1'b0;
      bus.wr_column   = '0;
      bus.rd_data     = '0;
      bus.rd_column   = '0;
      bus.rd_valid    = 1'b0;
      bus.done        = 1'b0;
      I_sdrc_cmd_en   = 1'b0;
      I_sdrc_cmd      = '0;
      I_sdrc_addr     = '0;
      I_sdrc_data     = '0;
      I_sdrc_data_len = '0;
      case (r_state)
         Init: if (O_sdrc_init_done) w_state = Idle;
         // Same-cycle expiry counts as pending so a coincident request waits.
         Idle: begin
            if (w_ref_pending || w_ref_expire) begin
               w_state = Refresh;
            end else if (bus.req_valid) begin
               bus.req_ready = 1'b1;
               w_accept      = 1'b1;
               w_state       = Activate;
            end
         end
         Refresh, RefreshAck: begin
            if (r_state == Refresh) begin
               I_sdrc_cmd_en = 1'b1;
               I_sdrc_cmd    = CmdRefresh;
               w_ref_clear   = 1'b1;
               w_state       = RefreshAck;
            end
            if (O_sdrc_cmd_ack) begin
               w_state = RefreshWait;
               w_cnt   = 4'(RefreshCycles - 1);
            end
         end
         RefreshWait: if (r_cnt == '0) w_state = Idle; else w_cnt = r_cnt - 4'd1;
         Activate, ActAck: begin
            if (r_state == Activate) begin
               I_sdrc_cmd_en = 1'b1;
               I_sdrc_cmd    = CmdActivate;
               I_sdrc_addr   = r_addr;
               w_state       = ActAck;
            end
            if (O_sdrc_cmd_ack) begin
               w_state = ActWait;
               w_cnt   = 4'(ActToRwCycles - 1);
            end
         end
         ActWait: begin
            if (r_cnt == '0) w_state = r_write ? WriteArm : Read;
            else             w_cnt   = r_cnt - 4'd1;
         end
         Read: begin
            I_sdrc_cmd_en   = 1'b1;
            I_sdrc_cmd      = CmdRead;
            I_sdrc_addr     = r_addr;
            I_sdrc_data_len = 8'(LineWords - 1);
            w_cnt           = 4'(ReadLatency - 1);
            w_col           = '0;
            w_state         = O_sdrc_cmd_ack ? ReadData : ReadAck;
         end
         // Latency keeps counting while the READ ack is outstanding.
         ReadAck, ReadData: begin
            if (r_state == ReadAck && O_sdrc_cmd_ack) w_state = ReadData;
            if (r_cnt != '0) begin
               w_cnt = r_cnt - 4'd1;
            end else begin
               bus.rd_valid  = 1'b1;
               bus.rd_column = r_col;
               bus.rd_data   = O_sdrc_data;
               w_col         = r_col + 3'd1;
               if (r_col == LastCol) w_state = Precharge;
            end
         end
         WriteArm: begin
            w_col     = '0;
            w_acked   = 1'b0;
            w_wr_last = 1'b0;
            w_state   = WriteData;
         end
         // Words stream every cycle regardless of ack; after the last word we only wait for ack.
         WriteData: begin
            if (!r_wr_last) begin
               I_sdrc_data   = bus.wr_data;
               bus.wr_column = (r_col == LastCol) ? 3'd0 : r_col + 3'd1;
               w_col         = r_col + 3'd1;
               if (r_col == LastCol) w_wr_last = 1'b1;
               if (r_col == '0) begin
                  I_sdrc_cmd_en   = 1'b1;
                  I_sdrc_cmd      = CmdWrite;
                  I_sdrc_addr     = r_addr;
                  I_sdrc_data_len = 8'(LineWords - 1);
               end
            end
            if (O_sdrc_cmd_ack) w_acked = 1'b1;
            if ((r_wr_last || r_col == LastCol) && (r_acked || O_sdrc_cmd_ack)) w_state = Precharge;
         end
         Precharge, PreAck: begin
            if (r_state == Precharge) begin
               I_sdrc_cmd_en = 1'b1;
               I_sdrc_cmd    = CmdPrecharge;
               I_sdrc_addr   = r_addr;
               w_state       = PreAck;
            end
            if (O_sdrc_cmd_ack) begin
               w_state = PreWait;
               w_cnt   = 4'(PrechargeCycles - 1);
            end
         end
         PreWait: if (r_cnt == '0) w_state = Done; else w_cnt = r_cnt - 4'd1;
         Done: begin
            bus.done = 1'b1;
            w_state  = Idle;
         end
         default: w_state = Init;
      endcase
   end
endmodule
